// File: rtl/input_conditioner3.sv
// Three-channel synchroniser + debouncer feeding the (a ^ b) | c stage.
// Every output is registered; chg pulses once per edge on which any channel output flips.
module input_conditioner3 #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    input  logic en,
    output logic a,
    output logic b,
    output logic c,
    output logic chg,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_e;

    logic [2:0]             raw;
    logic [2:0]             samp;
    logic [SYNC_STAGES-1:0] sync_q  [3];
    logic [SYNC_STAGES-1:0] sync_d  [3];
    state_e                 state_q [3];
    state_e                 state_d [3];
    logic [CNT_W-1:0]       cnt_q   [3];
    logic [CNT_W-1:0]       cnt_d   [3];
    logic [2:0]             out_q;
    logic [2:0]             out_d;
    logic                   chg_q;
    logic                   chg_d;
    logic                   busy_q;
    logic                   busy_d;

    assign raw = {c_in, b_in, a_in};

    // The shift chains run regardless of en; only the last stage is observed.
    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
            samp[ch]   = sync_q[ch][SYNC_STAGES-1];
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            out_d[ch]   = out_q[ch];
            unique case (state_q[ch])
                STABLE: begin
                    if (en && (samp[ch] != out_q[ch])) begin
                        // A one-sample debounce follows immediately without entering COUNTING.
                        if (CNT_LAST == '0) begin
                            out_d[ch] = samp[ch];
                        end else begin
                            cnt_d[ch]   = CNT_W'(1);
                            state_d[ch] = COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (!en || (samp[ch] == out_q[ch])) begin
                        cnt_d[ch]   = '0;
                        state_d[ch] = STABLE;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        out_d[ch]   = samp[ch];
                        cnt_d[ch]   = '0;
                        state_d[ch] = STABLE;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                    end
                end
            endcase
            busy_d = busy_d | (state_d[ch] == COUNTING);
        end
        chg_d = |(out_d ^ out_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                sync_q[ch]  <= '0;
                state_q[ch] <= STABLE;
                cnt_q[ch]   <= '0;
            end
            out_q  <= '0;
            chg_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                sync_q[ch]  <= sync_d[ch];
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            out_q  <= out_d;
            chg_q  <= chg_d;
            busy_q <= busy_d;
        end
    end

    assign a    = out_q[0];
    assign b    = out_q[1];
    assign c    = out_q[2];
    assign chg  = chg_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_input_conditioner3.sv
// Bench for input_conditioner3: default instance plus a SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance.
module tb_input_conditioner3;

    logic clk = 1'b0;
    logic rst_n;
    logic a_in, b_in, c_in, en;
    logic a, b, c, chg, busy;
    logic a1_in, b1_in, c1_in, en1;
    logic a1, b1, c1, chg1, busy1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    input_conditioner3 dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .c_in(c_in), .en(en),
        .a(a), .b(b), .c(c), .chg(chg), .busy(busy)
    );

    input_conditioner3 #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a_in(a1_in), .b_in(b1_in), .c_in(c1_in), .en(en1),
        .a(a1), .b(b1), .c(c1), .chg(chg1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the raw value seen at edge e is the one sampled S edges earlier;
    // an output flips after D consecutive enabled edges whose sample differs from it.
    typedef bit bitq_t[$];
    int    m_s [2] = '{2, 3};
    int    m_d [2] = '{16, 1};
    bitq_t hist [2][3];
    int    run  [2][3];
    bit    m_out[2][3];
    bit    m_chg [2];
    bit    m_busy[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int ch = 0; ch < 3; ch++) begin
                hist[m][ch] = {};
                for (int k = 0; k < m_s[m]; k++) hist[m][ch].push_back(1'b0);
                run[m][ch]   = 0;
                m_out[m][ch] = 1'b0;
            end
            m_chg[m]  = 1'b0;
            m_busy[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input bit [2:0] r, input bit e);
        bit s;
        bit flip = 1'b0;
        bit bz   = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            s = hist[m][ch].pop_front();
            hist[m][ch].push_back(r[ch]);
            if (!e || s == m_out[m][ch]) begin
                run[m][ch] = 0;
            end else begin
                run[m][ch]++;
                if (run[m][ch] >= m_d[m]) begin
                    m_out[m][ch] = s;
                    run[m][ch]   = 0;
                    flip         = 1'b1;
                end
            end
            if (run[m][ch] != 0) bz = 1'b1;
        end
        m_chg[0 + m]  = flip;
        m_busy[0 + m] = bz;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, {c_in, b_in, a_in}, en);
            model_step(1, {c1_in, b1_in, a1_in}, en1);
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            check("model0_abc_chg_busy", 32'({a, b, c, chg, busy}),
                  32'({m_out[0][0], m_out[0][1], m_out[0][2], m_chg[0], m_busy[0]}));
            check("model1_abc_chg_busy", 32'({a1, b1, c1, chg1, busy1}),
                  32'({m_out[1][0], m_out[1][1], m_out[1][2], m_chg[1], m_busy[1]}));
        end
    end

    typedef struct {
        logic [2:0] raw;      // {a_in, b_in, c_in}
        logic       en;
        int         hold;
        logic [2:0] exp_abc;  // {a, b, c}
        logic       exp_chg;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int got;
        int rise;
        int fall;
        int hold0[3];
        int hold1[3];
        logic [2:0] r0;
        logic [2:0] r1;

        tbl[0] = '{3'b000, 1'b1,  5, 3'b000, 1'b0, 1'b0};
        tbl[1] = '{3'b100, 1'b1, 10, 3'b000, 1'b0, 1'b1};
        tbl[2] = '{3'b100, 1'b1,  8, 3'b100, 1'b1, 1'b0};
        tbl[3] = '{3'b101, 1'b1, 20, 3'b101, 1'b0, 1'b0};
        tbl[4] = '{3'b111, 1'b0, 30, 3'b101, 1'b0, 1'b0};
        tbl[5] = '{3'b111, 1'b1, 15, 3'b101, 1'b0, 1'b1};
        tbl[6] = '{3'b111, 1'b1,  1, 3'b111, 1'b1, 1'b0};
        tbl[7] = '{3'b011, 1'b1,  3, 3'b111, 1'b0, 1'b1};
        tbl[8] = '{3'b111, 1'b1,  4, 3'b111, 1'b0, 1'b0};

        rst_n = 1'b0;
        {a_in, b_in, c_in} = 3'b000;
        {a1_in, b1_in, c1_in} = 3'b000;
        en = 1'b1;
        en1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut0", 32'({a, b, c, chg, busy}), 32'd0);
        check("reset_dut1", 32'({a1, b1, c1, chg1, busy1}), 32'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 9; i++) begin
            {a_in, b_in, c_in} = tbl[i].raw;
            en = tbl[i].en;
            repeat (tbl[i].hold) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_abc", i), 32'({a, b, c}), 32'(tbl[i].exp_abc));
            check($sformatf("vec%0d_chg", i), 32'(chg), 32'(tbl[i].exp_chg));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end

        // Asynchronous reset in the middle of a count.
        {a_in, b_in, c_in} = 3'b001;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("pre_reset_abc", 32'({a, b, c}), 32'b001);
        a_in = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({a, b, c, chg, busy}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (a === 1'b1) begin
                got = e;
                break;
            end
        end
        check("a_rise_edge_after_reset", 32'(got), 32'd18);
        @(negedge clk);

        // en low freezes channel C while its input toggles.
        {a_in, b_in, c_in} = 3'b000;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("settle_abc", 32'({a, b, c}), 32'd0);
        en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            c_in = ~c_in;
            @(negedge clk);
            check("en_low_c_chg_busy", 32'({c, chg, busy}), 32'd0);
        end
        c_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        got = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (c === 1'b1) begin
                got = e;
                break;
            end
        end
        check("c_rise_edge_after_en", 32'(got), 32'd16);
        @(negedge clk);

        // Unfiltered instance: latency SYNC_STAGES+1 and glitches pass through.
        a1_in = 1'b1;
        got = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (a1 === 1'b1) begin
                got = e;
                break;
            end
        end
        check("dut1_a_rise_edge", 32'(got), 32'd4);
        @(negedge clk);
        b1_in = 1'b1;
        rise = 0;
        fall = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (b1 === 1'b1 && rise == 0) rise = e;
            if (b1 === 1'b0 && rise != 0 && fall == 0) fall = e;
            @(negedge clk);
            if (e == 1) b1_in = 1'b0;
        end
        check("dut1_glitch_rise_edge", 32'(rise), 32'd4);
        check("dut1_glitch_fall_edge", 32'(fall), 32'd5);

        // Randomised run against the reference model.
        r0 = {c_in, b_in, a_in};
        r1 = {c1_in, b1_in, a1_in};
        for (int ch = 0; ch < 3; ch++) begin
            hold0[ch] = 0;
            hold1[ch] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int ch = 0; ch < 3; ch++) begin
                if (hold0[ch] == 0) begin
                    r0[ch] = ~r0[ch];
                    hold0[ch] = int'($urandom_range(1, 28));
                end else begin
                    hold0[ch]--;
                end
                if (hold1[ch] == 0) begin
                    r1[ch] = ~r1[ch];
                    hold1[ch] = int'($urandom_range(0, 5));
                end else begin
                    hold1[ch]--;
                end
            end
            {c_in, b_in, a_in} = r0;
            {c1_in, b1_in, a1_in} = r1;
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) en1 = ~en1;
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
